irq_pending: RTL

IRQ_PENDING -- requirements
Module: irq_pending

---
 rtl/irq_pending_pkg.sv | 10 +
 rtl/prio_enc8.sv | 13 +
 rtl/irq_pending.sv | 85 ++++++++
 3 files changed

// File: rtl/irq_pending_pkg.sv
// Shared constants and FSM state type for the irq_pending block.
package irq_pending_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational highest-set-bit encoder: 8-bit vector in, 3-bit index out.
// An all-zero input yields index 0.
module prio_enc8 (
    input  logic [7:0] vec,
    output logic [2:0] idx
);
    always_comb begin
        idx = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) idx = 3'(i);
        end
    end
endmodule

// File: rtl/irq_pending.sv
// Pending-request register plus a two-state presenter that grants the highest eligible line.
// Define IRQ_PENDING_EDGE_EN for rising-edge capture; the default is level capture.
module irq_pending #(
    parameter int N_REQ = irq_pending_pkg::N_REQ
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_in,
    input  logic [N_REQ-1:0]               mask,
    output logic                           d_valid,
    output logic [irq_pending_pkg::IDX_W-1:0] d_out,
    input  logic                           d_ack,
    output logic [N_REQ-1:0]               pend,
    output irq_pending_pkg::state_t        dbg_state
);
    import irq_pending_pkg::*;

    // Handshake: d_out is held stable while d_valid=1; a transfer happens on a
    // rising edge where d_valid=1 and d_ack=1. d_ack while d_valid=0 is ignored.

    state_t             state;
    logic [N_REQ-1:0]   p;
    logic [N_REQ-1:0]   set;
    logic [N_REQ-1:0]   clr;
    logic [N_REQ-1:0]   elig;
    logic [IDX_W-1:0]   top_idx;

`ifdef IRQ_PENDING_EDGE_EN
    logic [N_REQ-1:0]   req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_q <= '0;
        else     req_q <= req_in;
    end

    assign set = req_in & ~req_q;
`else
    assign set = req_in;
`endif

    assign clr  = (state == PRESENT && d_ack) ? (N_REQ'(1) << d_out) : '0;
    assign elig = p & ~mask;

    // Clear is applied first so a same-cycle set survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p <= '0;
        else     p <= (p & ~clr) | set;
    end

    prio_enc8 u_enc (
        .vec (elig),
        .idx (top_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            d_valid <= 1'b0;
            d_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig != '0) begin
                        state   <= PRESENT;
                        d_valid <= 1'b1;
                        d_out   <= top_idx;
                    end
                end
                PRESENT: begin
                    if (d_ack) begin
                        state   <= IDLE;
                        d_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    d_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pend      = p;
    assign dbg_state = state;
endmodule
